// File: rtl/mx_pow2_pkg.sv
// Shared exp2 definitions for the MX softmax datapath: default formats, derived widths,
// and the 2^(j/2^A) mantissa table generator.
package mx_pow2_pkg;

    localparam int LANES_DEF = 4;
    localparam int IN_W      = 8;
    localparam int IN_FI     = 4;
    localparam int OUT_W     = 10;
    localparam int OUT_FO    = 8;
    localparam int LUT_A     = 4;
    localparam int MANT_W    = OUT_FO + 1;
    localparam int SHIFT_W   = IN_W - IN_FI;

    // Mantissa for fractional step j of 2^a steps, rounded to nearest, scaled by 2^fo.
    function automatic int unsigned lut_init_val(input int unsigned j, input int unsigned a,
                                                 input int unsigned fo);
        real v;
        v = (2.0 ** (real'(j) / real'(1 << a))) * real'(1 << fo);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/power2_lut_rom.sv
// One lane's 2^f mantissa table: sync read-first, one write port, contents survive reset.
// Registered read enabled by i_rd_en; a same-edge write to the read address returns the old entry.
module power2_lut_rom
    import mx_pow2_pkg::*;
#(
    parameter int ADDR_W = LUT_A,
    parameter int DATA_W = MANT_W,
    parameter int FO     = OUT_FO
)(
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_dat,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat
);

    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic [DEPTH-1:0][DATA_W-1:0] init_mem();
        logic [DEPTH-1:0][DATA_W-1:0] m;
        for (int j = 0; j < DEPTH; j++) begin
            m[j] = DATA_W'(lut_init_val(j, ADDR_W, FO));
        end
        return m;
    endfunction

    // Power-up image only; deliberately untouched by reset so runtime rewrites persist.
    logic [DEPTH-1:0][DATA_W-1:0] r_mem = init_mem();
    logic [DATA_W-1:0]            r_rd_dat;

    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/power2_pipe.sv
// Multi-lane exp2 y = 2^x: integer part barrel-shifts a LUT mantissa indexed by the fraction.
// Latency 3 (S0 split, S1 LUT read, S2 shift/saturate); stages stall in place from data_out_0_ready.
module power2_pipe
    import mx_pow2_pkg::*;
#(
    parameter int LANES                  = LANES_DEF,
    parameter int DATA_IN_0_PRECISION_0  = IN_W,
    parameter int DATA_IN_0_PRECISION_1  = IN_FI,
    parameter int DATA_OUT_0_PRECISION_0 = OUT_W,
    parameter int DATA_OUT_0_PRECISION_1 = OUT_FO,
    parameter int LUT_ADDR_WIDTH         = LUT_A
)(
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [LANES*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                                    data_in_0_valid,
    output logic                                    data_in_0_ready,
    output logic [LANES*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                                    data_out_0_valid,
    input  logic                                    data_out_0_ready,
    input  logic                                    lut_wr_en,
    input  logic [LUT_ADDR_WIDTH-1:0]               lut_wr_addr,
    input  logic [DATA_OUT_0_PRECISION_1:0]         lut_wr_data
);

    localparam int IW = DATA_IN_0_PRECISION_0;
    localparam int FI = DATA_IN_0_PRECISION_1;
    localparam int OW = DATA_OUT_0_PRECISION_0;
    localparam int FO = DATA_OUT_0_PRECISION_1;
    localparam int A  = LUT_ADDR_WIDTH;
    localparam int MW = FO + 1;
    localparam int SW = IW - FI;

    // Left shifts past OW or spilling above OW saturate; right shifts of MW or more flush to 0.
    function automatic logic [OW-1:0] shift_sat(input logic [MW-1:0] m,
                                                input logic signed [SW-1:0] i);
        logic [MW+OW-1:0] wide;
        int               sh;
        sh   = int'(i);
        wide = {{OW{1'b0}}, m};
        if (sh >= 0) begin
            if (sh >= OW) begin
                return '1;
            end
            wide = wide << sh;
            return (|wide[MW+OW-1:OW]) ? '1 : wide[OW-1:0];
        end
        if (-sh >= MW) begin
            return '0;
        end
        wide = wide >> (-sh);
        return wide[OW-1:0];
    endfunction

    logic                      w_en0, w_en1, w_en2;
    logic [LANES-1:0][SW-1:0]  w_i;
    logic [LANES-1:0][A-1:0]   w_addr;
    logic [LANES-1:0][MW-1:0]  w_m;
    logic [LANES*OW-1:0]       w_y;

    logic                      r_v0, r_v1, r_out_vld;
    logic [LANES-1:0][SW-1:0]  r_i0, r_i1;
    logic [LANES-1:0][A-1:0]   r_addr0;
    logic [LANES*OW-1:0]       r_out_dat;

    assign w_en2 = !r_out_vld | data_out_0_ready;
    assign w_en1 = !r_v1 | w_en2;
    assign w_en0 = !r_v0 | w_en1;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_i[k]    = data_in_0[k*IW+FI +: SW];
        assign w_addr[k] = data_in_0[k*IW+FI-A +: A];

        power2_lut_rom #(
            .ADDR_W (A),
            .DATA_W (MW),
            .FO     (FO)
        ) u_lut (
            .clk       (clk),
            .i_rd_en   (w_en1 & r_v0),
            .i_rd_addr (r_addr0[k]),
            .o_rd_dat  (w_m[k]),
            .i_wr_en   (lut_wr_en),
            .i_wr_addr (lut_wr_addr),
            .i_wr_dat  (lut_wr_data)
        );

        assign w_y[k*OW +: OW] = shift_sat(w_m[k], r_i1[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_out_vld <= 1'b0;
            r_i0      <= '0;
            r_addr0   <= '0;
            r_i1      <= '0;
            r_out_dat <= '0;
        end else begin
            if (w_en0) begin
                r_v0 <= data_in_0_valid;
                if (data_in_0_valid) begin
                    r_i0    <= w_i;
                    r_addr0 <= w_addr;
                end
            end
            // The LUT read advances with S1, so r_i1 stays paired with the mantissa it selects.
            if (w_en1) begin
                r_v1 <= r_v0;
                if (r_v0) begin
                    r_i1 <= r_i0;
                end
            end
            if (w_en2) begin
                r_out_vld <= r_v1;
                if (r_v1) begin
                    r_out_dat <= w_y;
                end
            end
        end
    end

    assign data_in_0_ready  = w_en0;
    assign data_out_0       = r_out_dat;
    assign data_out_0_valid = r_out_vld;

endmodule

// File: tb/tb_power2_pipe.sv
// Bench for power2_pipe: directed beats, full-rate stream, random backpressure, LUT rewrite, reset.
module tb_power2_pipe;

    localparam int LANES = 4;
    localparam int IW    = 8;
    localparam int FI    = 4;
    localparam int OW    = 10;
    localparam int FO    = 8;
    localparam int A     = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [LANES*IW-1:0]   data_in_0 = '0;
    logic                  data_in_0_valid = 1'b0;
    logic                  data_in_0_ready;
    logic [LANES*OW-1:0]   data_out_0;
    logic                  data_out_0_valid;
    logic                  data_out_0_ready = 1'b1;
    logic                  lut_wr_en = 1'b0;
    logic [A-1:0]          lut_wr_addr = '0;
    logic [FO:0]           lut_wr_data = '0;

    always #5 clk = ~clk;

    power2_pipe dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .data_out_0       (data_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready),
        .lut_wr_en        (lut_wr_en),
        .lut_wr_addr      (lut_wr_addr),
        .lut_wr_data      (lut_wr_data)
    );

    typedef struct {
        logic [LANES*OW-1:0] y;
        int                  c;
    } exp_t;

    int                  n_pass = 0;
    int                  n_total = 0;
    int                  cyc = 0;
    int                  lut [1<<A];
    exp_t                q [$];
    logic [LANES*OW-1:0] tb_exp = '0;
    bit                  tb_use_exp = 1'b0;
    bit                  chk_lat = 1'b0;
    bit                  hold_pend = 1'b0;
    logic [LANES*OW-1:0] held = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    // Reference: y = LUT[frac] * 2^floor(x/2^FI), integer-truncated, clipped to OW bits.
    function automatic logic [LANES*OW-1:0] model(input logic [LANES*IW-1:0] xs);
        logic [LANES*OW-1:0] ys;
        logic signed [IW-1:0] xv;
        int    x, i, frac, addr;
        longint v;
        ys = '0;
        for (int k = 0; k < LANES; k++) begin
            xv   = xs[k*IW +: IW];
            x    = int'(xv);
            i    = $rtoi($floor(real'(x) / real'(1 << FI)));
            frac = x - i * (1 << FI);
            addr = frac / (1 << (FI - A));
            if (i >= 0) v = longint'(lut[addr]) * (longint'(1) << i);
            else        v = longint'(lut[addr]) / (longint'(1) << (-i));
            if (v > (1 << OW) - 1) v = (1 << OW) - 1;
            ys[k*OW +: OW] = OW'(v);
        end
        return ys;
    endfunction

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (hold_pend) begin
            check("hold_valid", 64'(data_out_0_valid), 64'd1);
            check("hold_data", 64'(data_out_0), 64'(held));
        end
        if (data_out_0_valid && data_out_0_ready) begin
            if (q.size() == 0) begin
                check("out_unexpected", 64'(data_out_0_valid), 64'd0);
            end else begin
                e = q.pop_front();
                check("out_data", 64'(data_out_0), 64'(e.y));
                if (chk_lat) check("latency", 64'(cyc - e.c), 64'd3);
            end
        end
        hold_pend = data_out_0_valid && !data_out_0_ready;
        held      = data_out_0;
        if (data_in_0_valid && data_in_0_ready) begin
            e.y = tb_use_exp ? tb_exp : model(data_in_0);
            e.c = cyc;
            q.push_back(e);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_exp(input logic [LANES*IW-1:0] x, input logic [LANES*OW-1:0] y);
        data_in_0       = x;
        data_in_0_valid = 1'b1;
        tb_exp          = y;
        tb_use_exp      = 1'b1;
        cycle();
        data_in_0_valid = 1'b0;
        tb_use_exp      = 1'b0;
    endtask

    task automatic idle(input int n);
        data_in_0_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        for (int j = 0; j < (1 << A); j++) begin
            lut[j] = $rtoi((2.0 ** (real'(j) / real'(1 << A))) * real'(1 << FO) + 0.5);
        end

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 64'(data_out_0_valid), 64'd0);
        check("rst_out_data", 64'(data_out_0), 64'd0);
        check("rst_in_ready", 64'(data_in_0_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lanes 3..0 = {-128, 16, -16, 0}
        chk_lat = 1'b1;
        send_exp({8'h80, 8'h10, 8'hF0, 8'h00}, {10'd1, 10'd512, 10'd128, 10'd256});
        idle(4);
        // Lanes 3..0 = {32, -8, 32, -8}: half-step LUT entry and left-shift saturation
        send_exp({8'h20, 8'hF8, 8'h20, 8'hF8}, {10'd1023, 10'd181, 10'd1023, 10'd181});
        idle(4);

        for (int b = 0; b < 16; b++) begin
            data_in_0       = $urandom;
            data_in_0_valid = 1'b1;
            cycle();
        end
        idle(5);
        check("stream_drained", 64'(q.size()), 64'd0);
        chk_lat = 1'b0;

        for (int b = 0; b < 120; b++) begin
            data_in_0        = $urandom;
            data_in_0_valid  = ($urandom_range(9, 0) < 7);
            data_out_0_ready = $urandom_range(1, 0) == 1;
            cycle();
        end
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
        for (int b = 0; b < 30 && q.size() > 0; b++) cycle();
        check("random_drained", 64'(q.size()), 64'd0);

        // The write lands on the same edge as this beat's LUT read, so the old entry is seen.
        send_exp(32'h0, {4{10'd256}});
        lut_wr_en   = 1'b1;
        lut_wr_addr = '0;
        lut_wr_data = 9'd300;
        cycle();
        lut_wr_en = 1'b0;
        lut[0]    = 300;
        send_exp(32'h0, {4{10'd300}});
        idle(4);

        for (int b = 0; b < 5; b++) begin
            data_in_0       = $urandom;
            data_in_0_valid = 1'b1;
            cycle();
        end
        rst_n = 1'b0;
        #2;
        check("midrst_valid", 64'(data_out_0_valid), 64'd0);
        check("midrst_data", 64'(data_out_0), 64'd0);
        q.delete();
        hold_pend       = 1'b0;
        data_in_0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        check("postrst_idle", 64'(data_out_0_valid), 64'd0);
        send_exp(32'h0, {4{10'd300}});
        idle(4);
        check("postrst_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
